// File: rtl/multicycle_control_fsm.sv
// multicycle_control_fsm: multi-cycle RV32I sequencer driving datapath controls and a shared memory port
module multicycle_control_fsm #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic             alu_zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             i_or_d,
  output logic             ir_write,
  output logic             pc_write,
  output logic             pc_src,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic             reg_write,
  output logic             mem_to_reg,
  output logic             instr_done,
  output logic             illegal_op,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] instr_retired
);
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  typedef enum logic [3:0] {
    FETCH     = 4'd0,
    DECODE    = 4'd1,
    MEM_ADDR  = 4'd2,
    MEM_READ  = 4'd3,
    MEM_WB    = 4'd4,
    MEM_WRITE = 4'd5,
    EXEC_R    = 4'd6,
    EXEC_I    = 4'd7,
    ALU_WB    = 4'd8,
    BRANCH    = 4'd9,
    TRAP      = 4'd10
  } state_t;
  state_t cur, nxt;
  assign state = cur;
  // state register, sticky illegal flag and retire counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur           <= FETCH;
      illegal_op    <= 1'b0;
      instr_retired <= '0;
    end else begin
      cur           <= nxt;
      illegal_op    <= illegal_op | (nxt == TRAP);
      instr_retired <= instr_retired + CNT_W'(instr_done);
    end
  end
  // next-state and control decode from state, mem_ready and IR fields
  always_comb begin
    nxt        = cur;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    i_or_d     = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 1'b0;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    instr_done = 1'b0;
    case (cur)
      FETCH: begin
        mem_req   = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        nxt       = mem_ready ? DECODE : FETCH;
      end
      DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        nxt = (opcode == OP_LOAD || opcode == OP_STORE) ? MEM_ADDR :
              (opcode == OP_R) ? EXEC_R :
              (opcode == OP_I) ? EXEC_I :
              (opcode == OP_BRANCH && funct3[2:1] == 2'b00) ? BRANCH : TRAP;
      end
      MEM_ADDR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b10;
        nxt       = (opcode == OP_LOAD) ? MEM_READ : MEM_WRITE;
      end
      MEM_READ: begin
        mem_req = 1'b1;
        i_or_d  = 1'b1;
        nxt     = mem_ready ? MEM_WB : MEM_READ;
      end
      MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        instr_done = 1'b1;
        nxt        = FETCH;
      end
      MEM_WRITE: begin
        mem_req    = 1'b1;
        mem_we     = 1'b1;
        i_or_d     = 1'b1;
        instr_done = mem_ready;
        nxt        = mem_ready ? FETCH : MEM_WRITE;
      end
      EXEC_R: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b10;
        nxt       = ALU_WB;
      end
      EXEC_I: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b10;
        nxt       = ALU_WB;
      end
      ALU_WB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
        nxt        = FETCH;
      end
      BRANCH: begin
        alu_src_a  = 2'b10;
        alu_op     = 2'b01;
        pc_src     = 1'b1;
        pc_write   = funct3[0] ? !alu_zero : alu_zero;
        instr_done = 1'b1;
        nxt        = FETCH;
      end
      TRAP:    nxt = TRAP;
      default: nxt = TRAP;
    endcase
  end
endmodule

// File: tb/tb_multicycle_control_fsm.sv
// tb_multicycle_control_fsm: directed per-cycle vectors checked through an expected-response queue
module tb_multicycle_control_fsm;
  localparam logic [6:0] ADDI = 7'b0010011, LW = 7'b0000011, SW = 7'b0100011;
  localparam logic [6:0] BR = 7'b1100011, RT = 7'b0110011, BAD = 7'b1111111;
  // {mem_req,mem_we,i_or_d,ir_write,pc_write,pc_src,src_a[2],src_b[2],alu_op[2],reg_write,mem_to_reg,instr_done,illegal_op}
  localparam logic [15:0] F_WAIT = 16'h8040, F_GO = 16'h9840, DEC = 16'h0180;
  localparam logic [15:0] MA = 16'h0280, EXI = 16'h0280, EXR = 16'h0220;
  localparam logic [15:0] MR = 16'hA000, MWB = 16'h000E, MW_GO = 16'hE002;
  localparam logic [15:0] AWB = 16'h000A, BR_NT = 16'h0612, BR_T = 16'h0E12, TRP = 16'h0001;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [6:0] opcode = '0;
  logic [2:0] funct3 = '0;
  logic alu_zero = 1'b0, mem_ready = 1'b0;
  logic mem_req, mem_we, i_or_d, ir_write, pc_write, pc_src, reg_write, mem_to_reg, instr_done, illegal_op;
  logic [1:0] alu_src_a, alu_src_b, alu_op;
  logic [3:0] state;
  logic [31:0] instr_retired;
  logic [15:0] ctl;
  int n_cmp = 0, n_bad = 0;
  typedef struct {logic [3:0] st; logic [15:0] ctl; int ret;} exp_t;
  exp_t q[$];
  multicycle_control_fsm #(.CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3), .alu_zero(alu_zero),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .i_or_d(i_or_d),
    .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .reg_write(reg_write), .mem_to_reg(mem_to_reg),
    .instr_done(instr_done), .illegal_op(illegal_op), .state(state), .instr_retired(instr_retired)
  );
  assign ctl = {mem_req, mem_we, i_or_d, ir_write, pc_write, pc_src, alu_src_a, alu_src_b,
                alu_op, reg_write, mem_to_reg, instr_done, illegal_op};
  always #5 clk = ~clk;
  // monitor: one expected vector per cycle, sampled mid-cycle
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      n_cmp++;
      if (state !== e.st || ctl !== e.ctl || instr_retired !== 32'(e.ret)) begin
        n_bad++;
        $display("FAIL cycle#%0d: got state=%0d ctl=%h retired=%0d, want state=%0d ctl=%h retired=%0d",
                 n_cmp, state, ctl, instr_retired, e.st, e.ctl, e.ret);
      end
    end
  end
  task automatic cyc(input logic [6:0] op, input logic [2:0] f3, input logic rdy, input logic z,
                     input logic [3:0] st, input logic [15:0] c, input int ret);
    exp_t e;
    @(posedge clk);
    #1;
    opcode = op; funct3 = f3; mem_ready = rdy; alu_zero = z;
    e.st = st; e.ctl = c; e.ret = ret;
    q.push_back(e);
  endtask
  task automatic release_rst();
    @(negedge clk);
    #1 rst_n = 1'b1;
  endtask
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask
  initial begin
    cyc(ADDI, 0, 0, 0, 0, F_WAIT, 0);
    release_rst();
    cyc(ADDI, 0, 1, 0, 0, F_GO, 0);
    cyc(ADDI, 0, 1, 0, 1, DEC, 0);
    cyc(ADDI, 0, 1, 0, 7, EXI, 0);
    cyc(ADDI, 0, 1, 0, 8, AWB, 0);
    cyc(LW, 0, 0, 0, 0, F_WAIT, 1);
    cyc(LW, 0, 0, 0, 0, F_WAIT, 1);
    cyc(LW, 0, 1, 0, 0, F_GO, 1);
    cyc(LW, 0, 1, 0, 1, DEC, 1);
    cyc(LW, 0, 1, 0, 2, MA, 1);
    cyc(LW, 0, 0, 0, 3, MR, 1);
    cyc(LW, 0, 0, 0, 3, MR, 1);
    cyc(LW, 0, 1, 0, 3, MR, 1);
    cyc(LW, 0, 1, 0, 4, MWB, 1);
    cyc(SW, 0, 1, 0, 0, F_GO, 2);
    cyc(SW, 0, 1, 0, 1, DEC, 2);
    cyc(SW, 0, 1, 0, 2, MA, 2);
    cyc(SW, 0, 1, 0, 5, MW_GO, 2);
    cyc(BR, 0, 1, 1, 0, F_GO, 3);
    cyc(BR, 0, 1, 1, 1, DEC, 3);
    cyc(BR, 0, 1, 1, 9, BR_T, 3);
    cyc(BR, 0, 1, 0, 0, F_GO, 4);
    cyc(BR, 0, 1, 0, 1, DEC, 4);
    cyc(BR, 0, 1, 0, 9, BR_NT, 4);
    cyc(BR, 1, 1, 0, 0, F_GO, 5);
    cyc(BR, 1, 1, 0, 1, DEC, 5);
    cyc(BR, 1, 1, 0, 9, BR_T, 5);
    cyc(BR, 1, 1, 1, 0, F_GO, 6);
    cyc(BR, 1, 1, 1, 1, DEC, 6);
    cyc(BR, 1, 1, 1, 9, BR_NT, 6);
    cyc(RT, 0, 1, 0, 0, F_GO, 7);
    cyc(RT, 0, 1, 0, 1, DEC, 7);
    cyc(RT, 0, 1, 0, 6, EXR, 7);
    cyc(RT, 0, 1, 0, 8, AWB, 7);
    cyc(BAD, 0, 1, 0, 0, F_GO, 8);
    cyc(BAD, 0, 1, 0, 1, DEC, 8);
    cyc(BAD, 0, 1, 0, 10, TRP, 8);
    cyc(BAD, 0, 1, 0, 10, TRP, 8);
    cyc(BAD, 0, 1, 0, 10, TRP, 8);
    @(negedge clk);
    #2 rst_n = 1'b0;
    cyc(BR, 4, 0, 0, 0, F_WAIT, 0);
    release_rst();
    cyc(BR, 4, 1, 0, 0, F_GO, 0);
    cyc(BR, 4, 1, 0, 1, DEC, 0);
    cyc(BR, 4, 1, 0, 10, TRP, 0);
    cyc(BR, 4, 1, 0, 10, TRP, 0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    cyc(ADDI, 0, 0, 0, 0, F_WAIT, 0);
    release_rst();
    cyc(ADDI, 0, 1, 0, 0, F_GO, 0);
    cyc(ADDI, 0, 1, 0, 1, DEC, 0);
    cyc(ADDI, 0, 1, 0, 7, EXI, 0);
    cyc(ADDI, 0, 1, 0, 8, AWB, 0);
    cyc(LW, 0, 1, 0, 0, F_GO, 1);
    cyc(LW, 0, 1, 0, 1, DEC, 1);
    cyc(LW, 0, 1, 0, 2, MA, 1);
    cyc(LW, 0, 0, 0, 3, MR, 1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_state", 32'(state), 0);
    check("async_retired", instr_retired, 0);
    check("async_done", 32'(instr_done), 0);
    check("async_req", 32'(mem_req), 1);
    cyc(LW, 0, 0, 0, 0, F_WAIT, 0);
    release_rst();
    cyc(ADDI, 0, 1, 0, 0, F_GO, 0);
    cyc(ADDI, 0, 1, 0, 1, DEC, 0);
    cyc(ADDI, 0, 1, 0, 7, EXI, 0);
    cyc(ADDI, 0, 1, 0, 8, AWB, 0);
    cyc(ADDI, 0, 0, 0, 0, F_WAIT, 1);
    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    #1;
    if (q.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d expected vectors left, want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
